sr_arb_serializer: RTL

SR_ARB_SERIALIZER -- requirements
Module: sr_arb_serializer

---
 rtl/sr_arb_serializer.sv | 97 +++++++++
 1 files changed

// File: rtl/sr_arb_serializer.sv
// Purpose : round-robin arbiter between two parallel-word requesters feeding one
//           parallel-in shift register that serializes the granted word.
// Latency : accept edge -> first serial bit valid next cycle; frame = WIDTH+2 cycles.
// Backpr. : requesters hold req until granted; no grant while a frame is in flight.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_a/data_a, req_b/data_b : requests and parallel words
//   gnt_a, gnt_b               : combinational grants (IDLE only)
//   q                          : shift register contents
//   ser_out, ser_valid         : serial bit and its qualifier
//   src_id                     : owner of current/last frame (0 = A, 1 = B)
//   busy, done                 : not-IDLE flag, end-of-frame pulse
module sr_arb_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             src_id,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_src;

  // Grants are suppressed while reset is low so that reset visibly wins over
  // an accept at the same edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset && state == IDLE) begin
      if (req_a && req_b) begin
        // Tie: the requester that did not own the last frame wins.
        gnt_a = last_src;
        gnt_b = ~last_src;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      q        <= '0;
      cnt      <= '0;
      src_id   <= 1'b0;
      last_src <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            q        <= gnt_b ? data_b : data_a;
            src_id   <= gnt_b;
            last_src <= gnt_b;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
          else           q <= {1'b0, q[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid & (MSB_FIRST ? q[WIDTH-1] : q[0]);

endmodule
